relu_maxpool2: RTL and testbench
================================

RELU_MAXPOOL2 -- requirements
Module: relu_maxpool2

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SIZE, 5, input matrix dimension (conv stage output: conv SIZE - kernel SIZE + 1).
- POOL, 2, square pooling window edge and stride.
- WIDTH_BIT, 8, element width, two's complement.
- RELU_EN, 1, 1 = clamp negative maxima to 0.
REQ-002 Derived OUT SHALL be floor(SIZE/POOL). Trailing rows/cols beyond OUT*POOL are ignored.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, request pooling of current inpMatrix.
- inpMatrix, in, WIDTH_BIT x [SIZE-1:0][SIZE-1:0], conv result matrix.
- busy, out, 1, run in progress.
- done, out, 1, one-cycle completion pulse.
- poolOut, out, WIDTH_BIT x [OUT-1:0][OUT-1:0], pooled result.
REQ-004 Clocking SHALL be one clock; reset SHALL be asynchronous and active-high.

Function
REQ-005 The FSM SHALL have the states IDLE, CAPTURE, SCAN, WRITE and DONE.
REQ-006 IDLE: start=1 at an edge -> CAPTURE; otherwise remain in IDLE. busy=0 only in IDLE.
REQ-007 CAPTURE: one cycle. At its closing edge, inpMatrix SHALL be snapshotted into an internal register and the window indices (wr,wc) and element indices (er,ec) cleared -> SCAN.
REQ-008 SCAN: one snapshot element per cycle, element [wr*POOL+er][wc*POOL+ec], with ec fastest.
- First element of a window loads the running max.
- Later elements replace it if strictly greater (signed compare).
- After POOL*POOL elements -> WRITE.
REQ-009 WRITE: one cycle.
- poolOut[wr][wc] <= (RELU_EN && max<0) ? 0 : max.
- Advance wc, then wr.
- Last window (wr=wc=OUT-1) -> DONE; else -> SCAN.
REQ-010 DONE: one cycle, done=1, then -> IDLE. done SHALL be 0 in all other states.
REQ-011 Latency SHALL be: start sampled at edge E0, done high during the cycle after edge E0+1+OUT*OUT*(POOL*POOL+1). For defaults this is 21 cycles.
REQ-012 start SHALL be ignored in every state except IDLE. start held high SHALL begin a new run on the edge after DONE.
REQ-013 inpMatrix changes after CAPTURE SHALL NOT affect the current run.
REQ-014 poolOut entries SHALL update only in WRITE and SHALL hold their value otherwise, including after done, until overwritten by a later run.
REQ-015 Comparisons SHALL be signed, WIDTH_BIT wide. No widening or saturation occurs. Equal values keep the earlier element, which leaves the result unchanged.
REQ-016 OUT=0 (SIZE<POOL) SHALL be illegal, and the block SHALL flag it with an elaboration-time error.

Reset
REQ-017 Assertion of reset SHALL immediately and asynchronously force:
- state = IDLE.
- busy=0, done=0.
- poolOut all 0, snapshot and indices all 0.
REQ-018 Reset mid-run SHALL abort the run with no done pulse. The first edge after deassertion SHALL sample start normally.

Verification
REQ-019 Defaults, inpMatrix[r][c]=r*5+c, one-cycle start -> done at cycle 21, poolOut={{6,8},{16,18}}, row 4 and col 4 ignored.
REQ-020 All elements -3, RELU_EN=1 -> poolOut all 0. The same stimulus with RELU_EN=0 -> poolOut all 8'hFD.
REQ-021 Window 0 = {127,-128,5,5}, other elements 0 -> poolOut[0][0]=127, confirming a signed compare and no wrap.
REQ-022 start pulsed again at cycles 3 and 10 of a run, and inpMatrix changed to all 1 after CAPTURE -> exactly one done at cycle 21, with results from the original snapshot.
REQ-023 Reset asserted at cycle 12, released at 14 -> no done, poolOut all 0, busy=0. A new start -> correct results after a further 21 cycles.
REQ-024 start held high continuously -> done pulses every 23 cycles, with busy low for exactly 1 cycle (IDLE) between runs.

Source files
------------

// File: rtl/relu_maxpool2.sv
// ReLU + max pooling over a square matrix: the input is snapshotted, then each
// POOLxPOOL window is scanned one element per cycle and its clamped maximum written out.
module relu_maxpool2 #(
  parameter int SIZE      = 5,
  parameter int POOL      = 2,
  parameter int WIDTH_BIT = 8,
  parameter bit RELU_EN   = 1'b1,
  localparam int OUT      = SIZE / POOL
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] inpMatrix,
  output logic                                      busy,
  output logic                                      done,
  output logic [OUT-1:0][OUT-1:0][WIDTH_BIT-1:0]   poolOut
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [IW-1:0] POOL_W    = IW'(POOL);
  localparam logic [IW-1:0] POOL_LAST = IW'(POOL - 1);
  localparam logic [IW-1:0] OUT_LAST  = IW'(OUT - 1);

  // A matrix smaller than one pooling window has no defined output.
  if (OUT < 1) begin : g_badSize
    $error("relu_maxpool2: SIZE must be >= POOL");
  end

  typedef enum logic [2:0] {IDLE, CAPTURE, SCAN, WRITE, DONE} state_t;

  state_t                                   r_state;
  state_t                                   w_next;
  logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] r_snap;
  logic [OUT-1:0][OUT-1:0][WIDTH_BIT-1:0]   r_pool;
  logic [IW-1:0]                            r_wr;
  logic [IW-1:0]                            r_wc;
  logic [IW-1:0]                            r_er;
  logic [IW-1:0]                            r_ec;
  logic [WIDTH_BIT-1:0]                     r_max;

  logic [IW-1:0]        w_row;
  logic [IW-1:0]        w_col;
  logic [WIDTH_BIT-1:0] w_elem;
  logic [WIDTH_BIT-1:0] w_relu;
  logic                 w_firstElem;
  logic                 w_lastElem;
  logic                 w_lastWin;

  assign w_row       = r_wr * POOL_W + r_er;
  assign w_col       = r_wc * POOL_W + r_ec;
  assign w_elem      = r_snap[w_row][w_col];
  assign w_firstElem = (r_er == '0) && (r_ec == '0);
  assign w_lastElem  = (r_er == POOL_LAST) && (r_ec == POOL_LAST);
  assign w_lastWin   = (r_wr == OUT_LAST) && (r_wc == OUT_LAST);
  assign w_relu      = (RELU_EN && r_max[WIDTH_BIT-1]) ? '0 : r_max;
  assign poolOut     = r_pool;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = CAPTURE;
      end
      CAPTURE: w_next = SCAN;
      SCAN:    if (w_lastElem) w_next = WRITE;
      WRITE:   w_next = w_lastWin ? DONE : SCAN;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Ties keep the earlier element, so only a strictly greater value replaces the max.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_snap <= '0;
      r_pool <= '0;
      r_wr   <= '0;
      r_wc   <= '0;
      r_er   <= '0;
      r_ec   <= '0;
      r_max  <= '0;
    end else begin
      case (r_state)
        CAPTURE: begin
          r_snap <= inpMatrix;
          r_wr   <= '0;
          r_wc   <= '0;
          r_er   <= '0;
          r_ec   <= '0;
        end
        SCAN: begin
          if (w_firstElem || ($signed(w_elem) > $signed(r_max))) r_max <= w_elem;
          if (r_ec == POOL_LAST) begin
            r_ec <= '0;
            r_er <= (r_er == POOL_LAST) ? '0 : r_er + 1'b1;
          end else begin
            r_ec <= r_ec + 1'b1;
          end
        end
        WRITE: begin
          r_pool[r_wr][r_wc] <= w_relu;
          if (r_wc == OUT_LAST) begin
            r_wc <= '0;
            r_wr <= (r_wr == OUT_LAST) ? '0 : r_wr + 1'b1;
          end else begin
            r_wc <= r_wc + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_maxpool2.sv
// Directed bench for relu_maxpool2: one instance with ReLU, one without,
// driven from a shared vector table plus multi-cycle corner-case sequences.
module tb_relu_maxpool2;

  typedef logic [4:0][4:0][7:0] mat_t;
  typedef logic [1:0][1:0][7:0] pool_t;
  typedef struct {
    mat_t  m;
    pool_t expA;
    pool_t expB;
  } vec_t;

  logic  clock;
  logic  reset;
  logic  start;
  mat_t  inpMatrix;
  logic  busyA, doneA, busyB, doneB;
  pool_t poolA, poolB;

  int total = 0;
  int bad = 0;
  int doneCount = 0;
  vec_t vecs[4];
  mat_t ones;

  relu_maxpool2 #(.SIZE(5), .POOL(2), .WIDTH_BIT(8), .RELU_EN(1'b1)) dutA (
    .clock(clock), .reset(reset), .start(start), .inpMatrix(inpMatrix),
    .busy(busyA), .done(doneA), .poolOut(poolA)
  );

  relu_maxpool2 #(.SIZE(5), .POOL(2), .WIDTH_BIT(8), .RELU_EN(1'b0)) dutB (
    .clock(clock), .reset(reset), .start(start), .inpMatrix(inpMatrix),
    .busy(busyB), .done(doneB), .poolOut(poolB)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) if (doneA) doneCount <= doneCount + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start for one edge and return the cycle index at which done is seen (-1 on timeout).
  task automatic applyStimulus(input mat_t m, output int lat);
    inpMatrix = m;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (doneA) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic checkPools(input string name, input pool_t expA, input pool_t expB);
    checkOutput({name, " poolA"}, 64'(poolA), 64'(expA));
    checkOutput({name, " poolB"}, 64'(poolB), 64'(expB));
  endtask

  initial begin
    int lat;
    int base;
    int k;
    int lowCnt;
    int doneAt[3];

    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        vecs[0].m[r][c] = 8'(r * 5 + c);
        vecs[1].m[r][c] = 8'hFD;
        vecs[2].m[r][c] = 8'h00;
        vecs[3].m[r][c] = (r == 4 || c == 4) ? 8'd100 : 8'h00;
        ones[r][c]      = 8'h01;
      end
    vecs[0].expA = {8'd18, 8'd16, 8'd8, 8'd6};
    vecs[0].expB = {8'd18, 8'd16, 8'd8, 8'd6};
    vecs[1].expA = '0;
    vecs[1].expB = {4{8'hFD}};
    vecs[2].m[0][0] = 8'h7F;
    vecs[2].m[0][1] = 8'h80;
    vecs[2].m[1][0] = 8'h05;
    vecs[2].m[1][1] = 8'h05;
    vecs[2].expA = {8'h00, 8'h00, 8'h00, 8'h7F};
    vecs[2].expB = {8'h00, 8'h00, 8'h00, 8'h7F};
    vecs[3].m[0][0] = 8'hFB;
    vecs[3].m[0][1] = 8'hFE;
    vecs[3].m[1][0] = 8'hF9;
    vecs[3].m[1][1] = 8'hFF;
    for (int r = 0; r < 2; r++)
      for (int c = 2; c < 4; c++) vecs[3].m[r][c] = 8'h80;
    for (int r = 2; r < 4; r++)
      for (int c = 0; c < 2; c++) vecs[3].m[r][c] = 8'd9;
    vecs[3].m[2][2] = 8'd3;
    vecs[3].m[2][3] = 8'h9C;
    vecs[3].m[3][2] = 8'd40;
    vecs[3].m[3][3] = 8'd41;
    vecs[3].expA = {8'd41, 8'd9, 8'h00, 8'h00};
    vecs[3].expB = {8'd41, 8'd9, 8'h80, 8'hFF};

    reset = 1'b1;
    start = 1'b0;
    inpMatrix = '0;
    #12;
    checkOutput("reset busy", 64'({busyA, busyB}), 64'd0);
    checkOutput("reset done", 64'({doneA, doneB}), 64'd0);
    checkPools("reset", '0, '0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].m, lat);
      checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'd21);
      checkOutput($sformatf("vec%0d doneB", i), 64'(doneB), 64'd1);
      @(posedge clock);
      #1;
      checkOutput($sformatf("vec%0d idle", i), 64'({busyA, doneA}), 64'd0);
      repeat (3) @(posedge clock);
      #1;
      checkPools($sformatf("vec%0d", i), vecs[i].expA, vecs[i].expB);
    end

    // Extra start pulses and a late matrix change must not disturb the run.
    base = doneCount;
    lat = -1;
    inpMatrix = vecs[0].m;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (n == 1) inpMatrix = ones;
      start = (n == 3 || n == 10);
      if (doneA && lat < 0) lat = n;
    end
    start = 1'b0;
    checkOutput("restart latency", 64'(lat), 64'd21);
    checkOutput("restart doneCount", 64'(doneCount - base), 64'd1);
    checkPools("restart", vecs[0].expA, vecs[0].expB);

    // Reset mid-run aborts without done and clears results.
    base = doneCount;
    inpMatrix = vecs[3].m;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clock);
      #1;
      if (n == 12) begin
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset busy", 64'(busyA), 64'd0);
        checkPools("async reset", '0, '0);
      end
      if (n == 14) #2 reset = 1'b0;
    end
    checkOutput("abort doneCount", 64'(doneCount - base), 64'd0);
    checkOutput("abort busy", 64'({busyA, busyB}), 64'd0);
    checkPools("abort", '0, '0);
    applyStimulus(vecs[3].m, lat);
    checkOutput("after abort latency", 64'(lat), 64'd21);
    repeat (2) @(posedge clock);
    #1;
    checkPools("after abort", vecs[3].expA, vecs[3].expB);

    // start held high: back-to-back runs with a single idle cycle between them.
    inpMatrix = vecs[0].m;
    k = 0;
    lowCnt = 0;
    doneAt[0] = -1;
    doneAt[1] = -1;
    doneAt[2] = -1;
    @(negedge clock);
    start = 1'b1;
    for (int n = 0; n < 80; n++) begin
      @(posedge clock);
      #1;
      if (doneA && k < 3) begin
        doneAt[k] = n;
        k++;
      end
      if (!busyA && k == 1) lowCnt++;
    end
    start = 1'b0;
    checkOutput("held first done", 64'(doneAt[0]), 64'd21);
    checkOutput("held period 1", 64'(doneAt[1] - doneAt[0]), 64'd23);
    checkOutput("held period 2", 64'(doneAt[2] - doneAt[1]), 64'd23);
    checkOutput("held idle cycles", 64'(lowCnt), 64'd1);
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock);
      #1;
      if (!busyA) begin
        lat = n;
        break;
      end
    end
    checkOutput("held drain", 64'(lat >= 0), 64'd1);
    checkPools("held", vecs[0].expA, vecs[0].expB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
